// File: rtl/pipe_chain.sv
// Elastic valid/ready register chain with bubble collapsing and a per-stage flush mask.
// Optional statistics counters are built only when PIPE_CHAIN_STAT_EN is defined.
module pipe_chain #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  input  logic [DEPTH-1:0] flush,
  output logic [DEPTH-1:0] stage_vld,
  output logic [CW-1:0]    occ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      kill_cnt
);

  logic [DEPTH-1:0] vldReg;
  logic [DEPTH-1:0] vldNext;
  logic [DEPTH-1:0] effVld;
  logic [DEPTH-1:0] acc;
  logic [DEPTH-1:0] srcVld;
  logic [WIDTH-1:0] dataReg [DEPTH];
  logic [WIDTH-1:0] srcData [DEPTH];
  logic [CW-1:0]    occReg;
  logic [CW-1:0]    occNext;

  // A flushed stage is treated as empty when deciding who may advance.
  assign effVld = vldReg & ~flush;

  always_comb begin
    acc = '0;
    acc[DEPTH-1] = ~effVld[DEPTH-1] | out_rdy;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      acc[i] = ~effVld[i] | acc[i+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gStage
      if (gi == 0) begin : gHead
        assign srcVld[gi]  = in_vld;
        assign srcData[gi] = in_data;
      end else begin : gBody
        assign srcVld[gi]  = effVld[gi-1];
        assign srcData[gi] = dataReg[gi-1];
      end
      assign vldNext[gi] = acc[gi] ? (srcVld[gi] & ~flush[gi]) : vldReg[gi];
    end
  endgenerate

  always_comb begin
    occNext = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occNext = occNext + CW'(vldNext[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vldReg <= '0;
      occReg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dataReg[i] <= '0;
      end
    end else begin
      vldReg <= vldNext;
      occReg <= occNext;
      for (int i = 0; i < DEPTH; i++) begin
        if (acc[i]) begin
          dataReg[i] <= srcData[i];
        end
      end
    end
  end

  assign in_rdy    = rst | acc[0];
  assign out_vld   = vldReg[DEPTH-1];
  assign out_data  = dataReg[DEPTH-1];
  assign stage_vld = vldReg;
  assign occ       = occReg;

`ifdef PIPE_CHAIN_STAT_EN
  localparam int KW = $clog2(DEPTH + 2);

  logic [DEPTH-1:0] killHeld;
  logic [DEPTH-1:0] killIn;
  logic [KW-1:0]    killSum;
  logic [16:0]      killSat;
  logic [15:0]      stallCntReg;
  logic [15:0]      killCntReg;

  // Entries lost either sitting in a flushed stage or moving into one.
  assign killHeld = vldReg & flush;
  assign killIn   = acc & srcVld & flush;

  always_comb begin
    killSum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      killSum = killSum + KW'(killHeld[i]) + KW'(killIn[i]);
    end
  end

  assign killSat = {1'b0, killCntReg} + 17'(killSum);

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCntReg <= '0;
      killCntReg  <= '0;
    end else begin
      if (in_vld && !acc[0] && stallCntReg != 16'hFFFF) begin
        stallCntReg <= stallCntReg + 16'd1;
      end
      killCntReg <= killSat[16] ? 16'hFFFF : killSat[15:0];
    end
  end

  assign stall_cnt = stallCntReg;
  assign kill_cnt  = killCntReg;
`else
  assign stall_cnt = 16'h0000;
  assign kill_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed plus randomized checks of pipe_chain against a slot-level behavioural model.
module tb_pipe_chain;
  localparam int DEPTH = 3;
  localparam int CW = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             in_vld;
  logic [15:0]      in_data;
  logic             in_rdy;
  logic             out_vld;
  logic [15:0]      out_data;
  logic             out_rdy;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] stage_vld;
  logic [CW-1:0]    occ;
  logic [15:0]      stall_cnt;
  logic [15:0]      kill_cnt;

  pipe_chain #(.WIDTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy), .flush(flush),
    .stage_vld(stage_vld), .occ(occ), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          mVld [DEPTH];
  logic [15:0] mData [DEPTH];
  int          mStall = 0;
  int          mKill = 0;
  logic        lastInRdy;
  logic [15:0] retired [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input is taken whenever the consumer drains or any slot is (or becomes, by flush) a hole.
  function automatic logic modelInRdy();
    if (rst || out_rdy) return 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mVld[i] == 0 || flush[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic modelEdge();
    int ev [DEPTH];
    int nV [DEPTH];
    logic [15:0] nD [DEPTH];
    int kills;
    bit adv;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mVld[i] = 0;
        mData[i] = 16'h0;
      end
      mStall = 0;
      mKill = 0;
      return;
    end
    if (in_vld && !modelInRdy()) mStall = (mStall < 65535) ? mStall + 1 : 65535;
    kills = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ev[i] = (mVld[i] != 0 && !flush[i]) ? 1 : 0;
      if (flush[i] && mVld[i] != 0) kills++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      adv = out_rdy;
      for (int j = i; j < DEPTH; j++) if (ev[j] == 0) adv = 1'b1;
      if (adv) begin
        nV[i] = (i == 0) ? int'(in_vld) : ev[i-1];
        nD[i] = (i == 0) ? in_data : mData[i-1];
        if (flush[i] && nV[i] != 0) begin
          kills++;
          nV[i] = 0;
        end
      end else begin
        nV[i] = mVld[i];
        nD[i] = mData[i];
      end
    end
    mKill = (mKill + kills > 65535) ? 65535 : mKill + kills;
    for (int i = 0; i < DEPTH; i++) begin
      mVld[i] = nV[i];
      mData[i] = nD[i];
    end
  endtask

  function automatic logic [15:0] expStall();
`ifdef PIPE_CHAIN_STAT_EN
    return 16'(mStall);
`else
    return 16'h0000;
`endif
  endfunction

  function automatic logic [15:0] expKill();
`ifdef PIPE_CHAIN_STAT_EN
    return 16'(mKill);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic step(input logic r, input logic iv, input logic [15:0] id,
                      input logic ordy, input logic [DEPTH-1:0] fl);
    logic [DEPTH-1:0] expV;
    int expOcc;
    rst = r;
    in_vld = iv;
    in_data = id;
    out_rdy = ordy;
    flush = fl;
    @(negedge clk);
    lastInRdy = in_rdy;
    chk("in_rdy", 32'(in_rdy), 32'(modelInRdy()));
    if (!r && out_vld && ordy) begin
      retired.push_back(out_data);
      $display("retire data=%h", out_data);
    end
    @(posedge clk);
    modelEdge();
    #1;
    expOcc = 0;
    for (int i = 0; i < DEPTH; i++) begin
      expV[i] = (mVld[i] != 0);
      expOcc += mVld[i];
    end
    chk("stage_vld", 32'(stage_vld), 32'(expV));
    chk("occ", 32'(occ), 32'(expOcc));
    chk("out_vld", 32'(out_vld), 32'(expV[DEPTH-1]));
    if (expV[DEPTH-1]) chk("out_data", 32'(out_data), 32'(mData[DEPTH-1]));
    chk("stall_cnt", 32'(stall_cnt), 32'(expStall()));
    chk("kill_cnt", 32'(kill_cnt), 32'(expKill()));
  endtask

  initial begin
    logic [15:0] killBase;
    rst = 1'b1;
    in_vld = 1'b0;
    in_data = 16'h0;
    out_rdy = 1'b0;
    flush = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mVld[i] = 0;
      mData[i] = 16'h0;
    end

    step(1, 0, 16'h0, 0, '0);
    step(1, 1, 16'hBEEF, 1, '0);
    chk("reset_out_vld", 32'(out_vld), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);

    // Streaming at full rate
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 16'(k), 1, '0);
      if (k == 2) chk("stream_early", 32'(out_vld), 32'h0);
      if (k == 3) begin
        chk("stream_first_vld", 32'(out_vld), 32'h1);
        chk("stream_first_data", 32'(out_data), 32'h0001);
      end
    end
    chk("stream_occ", 32'(occ), 32'h3);
    for (int k = 0; k < 4; k++) step(0, 0, 16'h0, 1, '0);

    // Back-pressure
    step(1, 0, 16'h0, 0, '0);
    for (int k = 0; k < 3; k++) step(0, 1, 16'h00A0 + 16'(k), 0, '0);
    step(0, 1, 16'h00A3, 0, '0);
    chk("bp_in_rdy", 32'(lastInRdy), 32'h0);
    chk("bp_occ", 32'(occ), 32'h3);
    retired.delete();
    step(0, 1, 16'h00A3, 1, '0);
    for (int k = 0; k < 4; k++) step(0, 0, 16'h0, 1, '0);
    chk("bp_count", 32'(retired.size()), 32'h4);
    for (int k = 0; k < 4 && k < retired.size(); k++) chk("bp_order", 32'(retired[k]), 32'h00A0 + 32'(k));

    // Bubble collapse
    step(1, 0, 16'h0, 0, '0);
    step(0, 1, 16'h0011, 0, '0);
    chk("bubble_in_rdy", 32'(lastInRdy), 32'h1);
    step(0, 0, 16'h0, 0, '0);
    step(0, 1, 16'h0022, 0, '0);
    chk("bubble_in_rdy", 32'(lastInRdy), 32'h1);
    step(0, 0, 16'h0, 0, '0);
    step(0, 0, 16'h0, 0, '0);
    chk("bubble_stage_vld", 32'(stage_vld), 32'b110);
    chk("bubble_occ", 32'(occ), 32'h2);

    // Flush of the middle stage while loading
    step(1, 0, 16'h0, 0, '0);
    step(0, 1, 16'h000A, 0, '0);
    step(0, 1, 16'h000B, 0, '0);
    step(0, 1, 16'h000C, 0, '0);
    killBase = kill_cnt;
    step(0, 1, 16'h000D, 0, 3'b010);
    chk("flush_stage_vld", 32'(stage_vld), 32'b101);
`ifdef PIPE_CHAIN_STAT_EN
    chk("flush_kill", 32'(kill_cnt - killBase), 32'h2);
`endif
    retired.delete();
    for (int k = 0; k < 4; k++) step(0, 0, 16'h0, 1, '0);
    chk("flush_count", 32'(retired.size()), 32'h2);
    if (retired.size() == 2) begin
      chk("flush_first", 32'(retired[0]), 32'h000A);
      chk("flush_second", 32'(retired[1]), 32'h000D);
    end

    // Reset mid-stream
    for (int k = 0; k < 3; k++) step(0, 1, 16'h0100 + 16'(k), 0, '0);
    step(1, 1, 16'h5555, 0, '0);
    chk("mid_rst_stage_vld", 32'(stage_vld), 32'h0);
    chk("mid_rst_out_data", 32'(out_data), 32'h0);
    chk("mid_rst_occ", 32'(occ), 32'h0);
    step(0, 1, 16'h1234, 1, '0);
    step(0, 0, 16'h0, 1, '0);
    chk("mid_rst_lat_early", 32'(out_vld), 32'h0);
    step(0, 0, 16'h0, 1, '0);
    chk("mid_rst_lat_vld", 32'(out_vld), 32'h1);
    chk("mid_rst_lat_data", 32'(out_data), 32'h1234);

`ifdef PIPE_CHAIN_STAT_EN
    // Stall counter saturation
    step(1, 0, 16'h0, 0, '0);
    for (int k = 0; k < 70000; k++) step(0, 1, 16'(k), 0, '0);
    chk("stall_saturate", 32'(stall_cnt), 32'hFFFF);
`endif

    // Randomized traffic
    step(1, 0, 16'h0, 0, '0);
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0) ? DEPTH'($urandom) : '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
